// File: rtl/instruction_memory_responder.sv
// Responder side of the instruction-fetch interface: a word array with a configurable
// number of wait states, a program-load write port, and fault flagging for bad fetches.
module instruction_memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned LATENCY      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instructionAddress,
    input  logic        redirect,
    input  logic        loadEnable,
    input  logic [31:0] loadAddress,
    input  logic [31:0] loadData,
    output logic [31:0] instructionData,
    output logic        instructionDataValid,
    output logic        instructionFault
);

    localparam int unsigned INDEX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = {1'b0, 32'(DEPTH_WORDS)} << 2;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    logic [31:0]        mem [DEPTH_WORDS];
    state_t             state;
    logic [31:0]        latchedAddress;
    logic [3:0]         waitCount;
    logic               enterRespond;
    logic [31:0]        lookupAddress;
    logic               lookupHit;
    logic [INDEX_W-1:0] lookupIndex;

    // Upper bound is compared on 33 bits so an offset that wrapped below BASE_ADDRESS
    // can never alias back into the window.
    function automatic logic in_window(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDRESS;
        return (addr[1:0] == 2'b00) && ({1'b0, offset} < SPAN_BYTES);
    endfunction

    function automatic logic [INDEX_W-1:0] word_index(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDRESS;
        return INDEX_W'(offset >> 2);
    endfunction

    // With a single wait state the lookup happens in ISSUE, before latchedAddress is updated.
    always_comb begin
        enterRespond  = 1'b0;
        lookupAddress = (state == ISSUE) ? instructionAddress : latchedAddress;
        if (!redirect && !loadEnable) begin
            unique case (state)
                ISSUE:   enterRespond = (LATENCY == 1);
                WAIT:    enterRespond = (waitCount == 4'd1);
                default: enterRespond = 1'b0;
            endcase
        end
        lookupHit   = in_window(lookupAddress);
        lookupIndex = word_index(lookupAddress);
    end

    assign instructionDataValid = (state == RESPOND) && (instructionAddress == latchedAddress)
                                  && !redirect && !loadEnable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ISSUE;
            latchedAddress   <= '0;
            waitCount        <= '0;
            instructionData  <= '0;
            instructionFault <= 1'b0;
        end else begin
            unique case (state)
                ISSUE: begin
                    latchedAddress <= instructionAddress;
                    if (redirect || loadEnable) begin
                        state <= ISSUE;
                    end else if (enterRespond) begin
                        state <= RESPOND;
                    end else begin
                        state     <= WAIT;
                        waitCount <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    waitCount <= waitCount - 4'd1;
                    // A late address change still lands in RESPOND; the valid compare masks it.
                    if (redirect || loadEnable) begin
                        state <= ISSUE;
                    end else if (enterRespond) begin
                        state <= RESPOND;
                    end else if (instructionAddress != latchedAddress) begin
                        state <= ISSUE;
                    end
                end
                RESPOND: begin
                    if (!instructionDataValid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase

            if (enterRespond) begin
                instructionFault <= !lookupHit;
                instructionData  <= lookupHit ? mem[lookupIndex] : 32'h0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (loadEnable && in_window(loadAddress)) begin
            mem[word_index(loadAddress)] <= loadData;
        end
    end

endmodule

// File: doc/instruction_memory_responder.md
Name: instruction_memory_responder

Overview:
- Responder end of the instruction-fetch interface. Fetch drives instructionAddress; this block returns instructionData qualified by instructionDataValid.
- Backed by a synchronous word array with a configurable access latency in wait states.
- A load port writes program images. instructionFault flags misaligned or out-of-range fetches for the future trap path.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the backing array (power of two).
- BASE_ADDRESS, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 1, cycles from address capture to response (1..15).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- instructionAddress  input  32  byte address requested by fetch.
- redirect  input  1  abort the in-flight access; asserted on flush or controlReset.
- loadEnable  input  1  write the backing array this cycle.
- loadAddress  input  32  byte address for the load write.
- loadData  input  32  word to write.
- instructionData  output  32  returned instruction word.
- instructionDataValid  output  1  instructionData is correct for the current instructionAddress.
- instructionFault  output  1  qualifies valid: access was misaligned or out of range.

Behaviour:
- Reset (async) state, applied immediately:
  - state = ISSUE.
  - latchedAddress = 0, waitCount = 0.
  - instructionData = 0, instructionFault = 0, instructionDataValid = 0.
  - Array contents are not reset.
- ISSUE:
  - Capture instructionAddress into latchedAddress.
  - If LATENCY==1, go to RESPOND; otherwise go to WAIT with waitCount = LATENCY-1.
- WAIT:
  - Decrement waitCount each cycle.
  - When waitCount==1 at the clock edge, go to RESPOND.
  - Abort to ISSUE if instructionAddress != latchedAddress, redirect, or loadEnable is high.
- Transition into RESPOND: register the outputs from latchedAddress.
  - Misaligned (bits[1:0]!=0) or outside [BASE_ADDRESS, BASE_ADDRESS+DEPTH_WORDS*4): instructionData = 0, instructionFault = 1.
  - Otherwise: instructionData = array[(latchedAddress-BASE_ADDRESS)>>2], instructionFault = 0.
- RESPOND:
  - instructionDataValid is combinational: (state==RESPOND) && (instructionAddress==latchedAddress) && !redirect && !loadEnable.
  - Stay in RESPOND while instructionAddress==latchedAddress and !redirect and !loadEnable. This covers a stalled fetch: valid stays high and the data is unchanged.
  - Otherwise go to ISSUE; the new address is captured in that ISSUE cycle.
- Latency:
  - Accepted address A in ISSUE at cycle t gives valid at cycle t+LATENCY.
  - Sequential throughput is one word per LATENCY+1 cycles, because ISSUE is a separate cycle.
- Load port:
  - The write happens at the clock edge when loadEnable is high.
  - An in-range, aligned loadAddress writes array[(loadAddress-BASE_ADDRESS)>>2]; any other address is ignored.
  - Valid is suppressed whenever loadEnable is high, and the state returns to ISSUE.
  - A write to latchedAddress during RESPOND is seen on the re-fetch.
- Simultaneous events:
  - reset beats everything.
  - redirect and loadEnable each force ISSUE.
  - An address change in the same cycle as the WAIT→RESPOND edge still enters RESPOND, but valid is masked by the compare, so the next cycle goes to ISSUE.
- Arithmetic:
  - Range check uses an unsigned 32-bit subtract.
  - The index is bits [log2(DEPTH_WORDS)+1:2] of the offset.
  - Offset wrap-around must not alias into range: compare against the full upper bound.
- Valid is never asserted for an address other than the one whose data is on instructionData.

Test Plan:
- LATENCY=1, array[0]=32'h0000_0013, array[1]=32'h0010_0093; fetch 0 then 4 → valid at cycle 1 with 32'h0000_0013. Address 4 is captured at cycle 2; valid at cycle 3 with 32'h0010_0093.
- LATENCY=3; address held at 32'h8 → valid exactly 3 cycles after ISSUE. Hold the address for 5 more cycles (stall) → valid stays high with the data unchanged.
- LATENCY=3; change the address from 32'h8 to 32'h20 during WAIT → no valid for 32'h8. Valid for 32'h20 arrives 3 cycles after its ISSUE.
- Fault cases, each giving valid=1, fault=1, data=0:
  - address 32'h6 (misaligned).
  - address BASE_ADDRESS+DEPTH_WORDS*4.
  - address 32'hFFFF_FFFC.
- Load word 32'hDEAD_BEEF at 32'h10 while 32'h10 is in RESPOND → valid drops in the load cycle, then re-asserts with 32'hDEAD_BEEF after LATENCY cycles.
- Assert reset asynchronously mid-WAIT → valid=0 and data=0 immediately, state ISSUE. Deassert → normal fetch resumes from the current address.
